// File: rtl/pc_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit_pkg
// Shared core definitions for the fetch stage: datapath width, the default
// reset PC and the fetch FSM state encoding.
// -----------------------------------------------------------------------------
package pc_fetch_unit_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,   // request outstanding at PC
      S_WAIT  = 2'd1,   // granted, waiting for the read data
      S_VALID = 2'd2,   // instruction held for decode
      S_ERR   = 2'd3    // misaligned next PC (alignment-check builds only)
   } state_e;

endpackage

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
// Holds the architectural PC, fetches the word at PC from instruction memory
// and presents {pc_o, inst_o} to decode. When decode accepts, the next PC
// computed combinationally by the NPC logic from pc_o is captured and the
// next fetch starts. Every output is a flop or a decode of flops.
//
// Ports:
//   clk, rstn          core clock, asynchronous active-low reset
//   imem_req/addr      fetch request and word address (out)
//   imem_gnt           imem accepts the request (in)
//   imem_rvalid/rdata  fetched word is valid (in)
//   inst_valid/inst_o  instruction held for decode (out)
//   pc_o               PC of inst_o (out)
//   inst_ready         decode accepts this cycle (in)
//   npc_i              next PC, sampled only on acceptance (in)
//   fetch_cnt          instructions accepted by decode, wrapping (out)
//   misalign_o         misaligned-fetch error (out)
//
// Build option:
//   PC_FETCH_ALIGN_CHK_EN  accepting a next PC with npc_i[1:0] != 0 parks the
//                          unit in S_ERR until reset. Without it, misalign_o
//                          is tied 0 and the low two address bits are forced
//                          to zero on the imem port only.
// -----------------------------------------------------------------------------
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int              CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rstn,
   output logic              imem_req,
   output logic [XLEN-1:0]   imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [XLEN-1:0]   imem_rdata,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [XLEN-1:0]   inst_o,
   output logic [XLEN-1:0]   pc_o,
   input  logic [XLEN-1:0]   npc_i,
   output logic [CNT_W-1:0]  fetch_cnt,
   output logic              misalign_o
);

`ifdef PC_FETCH_ALIGN_CHK_EN
   if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
      $error("pc_fetch_unit: RESET_PC must be word aligned");
   end
`endif

   state_e             state_q, state_d;
   logic               run_q, run_d;
   logic [XLEN-1:0]    pc_q, pc_d;
   logic [XLEN-1:0]    inst_q, inst_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   // run_q stays low through the edge on which rstn rises, so the first
   // request appears one cycle after release and that edge makes no move.
   always_comb begin
      // NOTE: every signal gets a default before the case so that paths which
      // do not assign it hold the flop value instead of inferring a latch.
      state_d = state_q;
      run_d   = 1'b1;
      pc_d    = pc_q;
      inst_d  = inst_q;
      cnt_d   = cnt_q;

      case (state_q)
         S_REQ: begin
            if (run_q && imem_gnt) begin
               if (imem_rvalid) begin
                  inst_d  = imem_rdata;
                  state_d = S_VALID;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end

         S_WAIT: begin
            if (imem_rvalid) begin
               inst_d  = imem_rdata;
               state_d = S_VALID;
            end
         end

         S_VALID: begin
            if (inst_ready) begin
               pc_d    = npc_i;
               cnt_d   = cnt_q + CNT_W'(1);
`ifdef PC_FETCH_ALIGN_CHK_EN
               state_d = (npc_i[1:0] != 2'b00) ? S_ERR : S_REQ;
`else
               state_d = S_REQ;
`endif
            end
         end

`ifdef PC_FETCH_ALIGN_CHK_EN
         S_ERR: state_d = S_ERR;
`endif

         default: state_d = S_REQ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_REQ;
         run_q   <= 1'b0;
         pc_q    <= RESET_PC;
         inst_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         cnt_q   <= cnt_d;
      end
   end

   assign imem_req   = run_q && (state_q == S_REQ);
   assign inst_valid = (state_q == S_VALID);
   assign inst_o     = inst_q;
   assign pc_o       = pc_q;
   assign fetch_cnt  = cnt_q;

`ifdef PC_FETCH_ALIGN_CHK_EN
   assign imem_addr  = pc_q;
   assign misalign_o = (state_q == S_ERR);
`else
   // The PC keeps the raw next-PC value; only the bus address is aligned.
   assign imem_addr  = {pc_q[XLEN-1:2], 2'b00};
   assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
// Self-checking bench for pc_fetch_unit: a vector table for the back-to-back
// fetch stream, hand sequences for the multi-cycle corners, and randomized
// fetch transactions checked against a transaction-level reference.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rstn;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_o;
   logic [31:0] pc_o;
   logic [31:0] npc_i;
   logic [31:0] fetch_cnt;
   logic        misalign_o;

   int n_cmp = 0;
   int n_bad = 0;

   pc_fetch_unit #(.RESET_PC(32'h0000_3000), .CNT_W(32)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst_o      (inst_o),
      .pc_o        (pc_o),
      .npc_i       (npc_i),
      .fetch_cnt   (fetch_cnt),
      .misalign_o  (misalign_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        ready;
      logic [31:0] npc;
      logic        exp_req;
      logic        exp_valid;
      logic [31:0] exp_addr;
      logic [31:0] exp_inst;
      logic [31:0] exp_pc;
      logic [31:0] exp_cnt;
   } vec_t;

   vec_t tbl [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic gnt, input logic rv, input logic [31:0] rd,
                        input logic rdy, input logic [31:0] npc);
      imem_gnt    = gnt;
      imem_rvalid = rv;
      imem_rdata  = rd;
      inst_ready  = rdy;
      npc_i       = npc;
   endtask

   // Advance one clock and sample just after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reset, release on a falling edge, then run the release edge so the
   // unit is requesting at RESET_PC when this returns.
   task automatic do_reset();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      cyc();
   endtask

   logic [31:0] word, exp_pc, exp_cnt, nxt, wrap_pc;
   int          gd, wd, sd;

   initial begin
      // Back-to-back stream: gnt/rvalid/ready tied high, npc = pc_o + 4.
      tbl[0] = '{1, 1, 32'h2008_0005, 1, 32'hDEAD_BEE0, 0, 1, 32'h0,         32'h2008_0005, 32'h0000_3000, 0};
      tbl[1] = '{1, 1, 32'h2008_0005, 1, 32'h0000_3004, 1, 0, 32'h0000_3004, 32'h2008_0005, 32'h0000_3004, 1};
      tbl[2] = '{1, 1, 32'h2008_0005, 1, 32'h1234_5678, 0, 1, 32'h0,         32'h2008_0005, 32'h0000_3004, 1};
      tbl[3] = '{1, 1, 32'h2008_0005, 1, 32'h0000_3008, 1, 0, 32'h0000_3008, 32'h2008_0005, 32'h0000_3008, 2};
      tbl[4] = '{1, 1, 32'h2008_0005, 1, 32'h0000_0000, 0, 1, 32'h0,         32'h2008_0005, 32'h0000_3008, 2};
      tbl[5] = '{1, 1, 32'h2008_0005, 1, 32'h0000_300C, 1, 0, 32'h0000_300C, 32'h2008_0005, 32'h0000_300C, 3};

      // ---------------- reset state ----------------
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req",      {31'b0, imem_req},   32'h0);
      check("rst_valid",    {31'b0, inst_valid}, 32'h0);
      check("rst_inst",     inst_o,              32'h0);
      check("rst_cnt",      fetch_cnt,           32'h0);
      check("rst_misalign", {31'b0, misalign_o}, 32'h0);
      check("rst_pc",       pc_o,                32'h0000_3000);
      @(negedge clk);
      rstn = 1'b1;
      check("release_req_low", {31'b0, imem_req}, 32'h0);
      cyc();
      check("first_req",  {31'b0, imem_req}, 32'h1);
      check("first_addr", imem_addr,          32'h0000_3000);

      // ---------------- vector table: 2 cycles per instruction ----------------
      for (int i = 0; i < 6; i++) begin
         drive(tbl[i].gnt, tbl[i].rvalid, tbl[i].rdata, tbl[i].ready, tbl[i].npc);
         cyc();
         check($sformatf("tbl%0d_req", i),   {31'b0, imem_req},   {31'b0, tbl[i].exp_req});
         check($sformatf("tbl%0d_valid", i), {31'b0, inst_valid}, {31'b0, tbl[i].exp_valid});
         if (tbl[i].exp_req)
            check($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].exp_addr);
         check($sformatf("tbl%0d_inst", i),  inst_o,    tbl[i].exp_inst);
         check($sformatf("tbl%0d_pc", i),    pc_o,      tbl[i].exp_pc);
         check($sformatf("tbl%0d_cnt", i),   fetch_cnt, tbl[i].exp_cnt);
      end

      // ---------------- delayed grant, delayed rvalid ----------------
      do_reset();
      check("dly_req0",  {31'b0, imem_req}, 32'h1);
      check("dly_addr0", imem_addr,          32'h0000_3000);
      for (int k = 1; k <= 3; k++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
         cyc();
         check($sformatf("dly_req%0d", k),  {31'b0, imem_req}, 32'h1);
         check($sformatf("dly_addr%0d", k), imem_addr,          32'h0000_3000);
      end
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      cyc();
      check("dly_wait_req", {31'b0, imem_req}, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      cyc();
      check("dly_wait_valid", {31'b0, inst_valid}, 32'h0);
      drive(1'b0, 1'b1, 32'hA5A5_1234, 1'b0, 32'h0);
      cyc();
      check("dly_valid", {31'b0, inst_valid}, 32'h1);
      check("dly_inst",  inst_o,              32'hA5A5_1234);

      // ---------------- decode stall with stray rvalid ----------------
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, k[0], 32'hFFFF_0000 ^ 32'(k), 1'b0, 32'h0000_5550);
         cyc();
         check($sformatf("stall%0d_inst", k),  inst_o,              32'hA5A5_1234);
         check($sformatf("stall%0d_pc", k),    pc_o,                32'h0000_3000);
         check($sformatf("stall%0d_req", k),   {31'b0, imem_req},   32'h0);
         check($sformatf("stall%0d_valid", k), {31'b0, inst_valid}, 32'h1);
      end

      // ---------------- jump ----------------
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0010);
      cyc();
      check("jump_req",  {31'b0, imem_req}, 32'h1);
      check("jump_addr", imem_addr,          32'h0040_0010);
      check("jump_cnt",  fetch_cnt,          32'd1);
      drive(1'b1, 1'b1, 32'h0000_0013, 1'b0, 32'h0);
      cyc();
      check("jump_valid", {31'b0, inst_valid}, 32'h1);
      check("jump_pc",    pc_o,                32'h0040_0010);

      // ---------------- misaligned next PC ----------------
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3006);
      cyc();
`ifdef PC_FETCH_ALIGN_CHK_EN
      for (int k = 0; k < 4; k++) begin
         check($sformatf("err%0d_misalign", k), {31'b0, misalign_o}, 32'h1);
         check($sformatf("err%0d_req", k),      {31'b0, imem_req},   32'h0);
         check($sformatf("err%0d_valid", k),    {31'b0, inst_valid}, 32'h0);
         drive(1'b1, 1'b1, 32'h1, 1'b1, 32'h0000_3000);
         cyc();
      end
`else
      check("mis_misalign", {31'b0, misalign_o}, 32'h0);
      check("mis_req",      {31'b0, imem_req},   32'h1);
      check("mis_addr",     imem_addr,           32'h0000_3004);
      drive(1'b1, 1'b1, 32'h0000_0033, 1'b0, 32'h0);
      cyc();
      check("mis_pc_raw", pc_o, 32'h0000_3006);
`endif

      // ---------------- PC wrap ----------------
      do_reset();
      drive(1'b1, 1'b1, 32'h0000_0001, 1'b0, 32'h0);
      cyc();
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
      cyc();
      check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
      drive(1'b1, 1'b1, 32'h0000_0002, 1'b0, 32'h0);
      cyc();
      check("wrap_pc_top", pc_o, 32'hFFFF_FFFC);
      wrap_pc = 32'hFFFF_FFFC + 32'd4;
      drive(1'b0, 1'b0, 32'h0, 1'b1, wrap_pc);
      cyc();
      check("wrap_addr_zero", imem_addr, 32'h0000_0000);
      check("wrap_cnt",       fetch_cnt, 32'd2);

      // ---------------- randomized transactions ----------------
      do_reset();
      exp_pc  = 32'h0000_3000;
      exp_cnt = 0;
      for (int t = 0; t < 150; t++) begin
         word = $urandom;
         check("rnd_req",  {31'b0, imem_req}, 32'h1);
         check("rnd_addr", imem_addr,          exp_pc & 32'hFFFF_FFFC);
         gd = $urandom_range(0, 3);
         for (int k = 0; k < gd; k++) begin
            drive(1'b0, 1'($urandom), $urandom, 1'($urandom), $urandom);
            cyc();
            check("rnd_hold_req",  {31'b0, imem_req}, 32'h1);
            check("rnd_hold_addr", imem_addr,          exp_pc & 32'hFFFF_FFFC);
         end
         if ($urandom_range(0, 1) == 1) begin
            drive(1'b1, 1'b1, word, 1'($urandom), $urandom);
            cyc();
         end else begin
            drive(1'b1, 1'b0, $urandom, 1'($urandom), $urandom);
            cyc();
            wd = $urandom_range(0, 3);
            for (int k = 0; k < wd; k++) begin
               check("rnd_wait_req",   {31'b0, imem_req},   32'h0);
               check("rnd_wait_valid", {31'b0, inst_valid}, 32'h0);
               drive(1'($urandom), 1'b0, $urandom, 1'($urandom), $urandom);
               cyc();
            end
            drive(1'($urandom), 1'b1, word, 1'($urandom), $urandom);
            cyc();
         end
         check("rnd_valid", {31'b0, inst_valid}, 32'h1);
         check("rnd_inst",  inst_o,              word);
         check("rnd_pc",    pc_o,                exp_pc);
         check("rnd_cnt",   fetch_cnt,           exp_cnt);
         sd = $urandom_range(0, 3);
         for (int k = 0; k < sd; k++) begin
            drive(1'($urandom), 1'($urandom), $urandom, 1'b0, $urandom);
            cyc();
            check("rnd_stall_inst", inst_o,            word);
            check("rnd_stall_pc",   pc_o,              exp_pc);
            check("rnd_stall_req",  {31'b0, imem_req}, 32'h0);
         end
         nxt = $urandom;
`ifdef PC_FETCH_ALIGN_CHK_EN
         nxt = nxt & 32'hFFFF_FFFC;
`endif
         drive(1'($urandom), 1'($urandom), $urandom, 1'b1, nxt);
         cyc();
         exp_pc  = nxt;
         exp_cnt = exp_cnt + 1;
         check("rnd_acc_valid",    {31'b0, inst_valid}, 32'h0);
         check("rnd_acc_cnt",      fetch_cnt,           exp_cnt);
         check("rnd_acc_misalign", {31'b0, misalign_o}, 32'h0);
         drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      end

      // ---------------- reset while waiting, late rvalid ----------------
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      cyc();
      check("rw_in_wait", {31'b0, imem_req}, 32'h0);
      rstn = 1'b0;
      #1;
      check("rw_async_cnt",   fetch_cnt,           32'h0);
      check("rw_async_pc",    pc_o,                32'h0000_3000);
      check("rw_async_valid", {31'b0, inst_valid}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0, 32'h0);
      rstn = 1'b1;
      cyc();
      check("rw_req",   {31'b0, imem_req},   32'h1);
      check("rw_addr",  imem_addr,           32'h0000_3000);
      check("rw_valid", {31'b0, inst_valid}, 32'h0);
      check("rw_cnt",   fetch_cnt,           32'h0);
      cyc();
      check("rw_late_ignored", {31'b0, inst_valid}, 32'h0);
      check("rw_inst_clear",   inst_o,              32'h0);
      drive(1'b1, 1'b1, 32'h1357_9BDF, 1'b0, 32'h0);
      cyc();
      check("rw_refetch_inst", inst_o, 32'h1357_9BDF);
      check("rw_refetch_pc",   pc_o,   32'h0000_3000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Sequential counterpart to the next-PC logic: holds the architectural PC, fetches the instruction at PC from instruction memory, and presents {PC, instruction} to decode.
- When decode accepts, captures the next-PC value that was computed combinationally from the presented PC, and starts the next fetch.
- Sits between the imem port and the decode/NPC stage of the multi-cycle core.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded at reset.
- CNT_W, 32, width of the retired-fetch counter.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request; held high until granted.
- imem_addr  output  32  fetch address; equals the PC register while imem_req is high.
- imem_gnt  input  1  imem accepts the request this cycle.
- imem_rvalid  input  1  imem_rdata is valid this cycle.
- imem_rdata  input  32  fetched instruction word.
- inst_valid  output  1  inst_o and pc_o are valid for decode.
- inst_ready  input  1  decode accepts this cycle.
- inst_o  output  32  registered instruction.
- pc_o  output  32  PC of inst_o.
- npc_i  input  32  next PC from NPC logic; sampled only when inst_valid and inst_ready are both high.
- fetch_cnt  output  CNT_W  count of instructions accepted by decode.
- misalign_o  output  1  misaligned-fetch error; present only with the optional feature, otherwise tied 0.

Behaviour:
- Reset (rstn low, asynchronous):
  - PC = RESET_PC, state = S_REQ.
  - imem_req = 0, inst_valid = 0, inst_o = 0, fetch_cnt = 0, misalign_o = 0.
  - The first request is asserted in the first cycle after rstn deasserts; the clock edge on which rstn rises performs no transition.
- Outputs are registered or decoded from state only; nothing is combinational from an input.
- States:
  - S_REQ: imem_req = 1, imem_addr = PC.
    - imem_gnt & imem_rvalid in the same cycle: latch imem_rdata into inst_o, go to S_VALID.
    - imem_gnt only: go to S_WAIT.
    - Otherwise: stay in S_REQ with address stable.
  - S_WAIT: imem_req = 0. On imem_rvalid, latch imem_rdata into inst_o and go to S_VALID.
  - S_VALID: inst_valid = 1, pc_o = PC, inst_o stable.
    - On inst_ready: PC <= npc_i, fetch_cnt += 1 (wraps at 2^CNT_W - 1 to 0), go to S_REQ.
  - S_ERR: feature-only state, described under Optional Feature.
- Minimum latency: 1 cycle from S_REQ to S_VALID (gnt and rvalid together); 2 cycles per instruction at best.
- Ignored inputs:
  - imem_rvalid outside S_REQ/S_WAIT is ignored.
  - inst_ready outside S_VALID is ignored, and npc_i is not sampled.
- imem_rdata is never taken while in S_VALID; the instruction register is single-entry.
- PC wrap: npc_i is taken unmodified, so 32'hFFFF_FFFC followed by a +4 NPC gives 0.
- Reset asserted mid-fetch (S_WAIT): state is dropped immediately. A late imem_rvalid arriving after reset release, before a new grant, is ignored because the FSM is in S_REQ without a grant.

Optional Feature:
- Macro: PC_FETCH_ALIGN_CHK_EN.
- Defined:
  - On acceptance, if npc_i[1:0] != 2'b00, PC is still loaded but the FSM enters S_ERR instead of S_REQ.
  - In S_ERR: imem_req = 0, inst_valid = 0, misalign_o = 1. The state is left only by reset.
  - The RESET_PC alignment is checked at elaboration.
- Undefined:
  - No S_ERR, misalign_o is tied 0.
  - imem_addr[1:0] is forced to 2'b00; the PC register keeps the raw value.

Decomposition:
- Shared core package holds:
  - state encoding localparams S_REQ = 2'd0, S_WAIT = 2'd1, S_VALID = 2'd2, S_ERR = 2'd3;
  - the RESET_PC default and XLEN = 32.
- NPC op encodings remain in the existing encode header; this block does not decode them.
- No sub-module is needed; the fetch counter is inline.

Test Plan:
- Reset release with imem_gnt = 1 and imem_rvalid = 1 tied high, imem_rdata = 32'h2008_0005, inst_ready = 1, npc_i = pc_o + 4 → imem_addr sequence 0x3000, 0x3004, 0x3008; one instruction every 2 cycles; fetch_cnt = 3 after 3 accepts.
- Grant delayed 3 cycles, then rvalid 2 cycles after grant → imem_addr held at 0x3000 with imem_req = 1 for 4 cycles; inst_valid rises the cycle after rvalid with inst_o = rdata.
- Decode stalls (inst_ready = 0 for 5 cycles) while imem_rvalid pulses with a different word → inst_o and pc_o unchanged, no new imem_req.
- Jump: accept with npc_i = 0x0040_0010 → next imem_addr = 0x0040_0010, pc_o = 0x0040_0010 on the next valid.
- rstn pulsed low while in S_WAIT, then rvalid arrives after release → the response is ignored; the first request goes out at 0x3000 and fetch_cnt = 0.
- With PC_FETCH_ALIGN_CHK_EN: accept with npc_i = 0x3006 → misalign_o = 1, imem_req = 0, held until reset. Without the macro: imem_addr = 0x3004.
